// File: rtl/prv_trap_pkg.sv
// Shared definitions for the machine-mode trap sequencer: state encoding,
// mstatus field positions and the latched trap cause record.
package prv_trap_pkg;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FLUSH    = 3'd1;
    localparam logic [2:0] S_COMMIT   = 3'd2;
    localparam logic [2:0] S_MRET     = 3'd3;
    localparam logic [2:0] S_REDIRECT = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = S_IDLE,
        ST_FLUSH    = S_FLUSH,
        ST_COMMIT   = S_COMMIT,
        ST_MRET     = S_MRET,
        ST_REDIRECT = S_REDIRECT
    } trap_state_t;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    typedef struct packed {
        logic       intr;
        logic [3:0] code;
    } cause_t;

endpackage

// File: rtl/prv_irq_prio.sv
// Masked interrupt priority encoder: the lowest-numbered pending line wins.
module prv_irq_prio #(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] mask,
    output logic               valid,
    output logic [3:0]         index
);

    logic [NUM_IRQ-1:0] pending;

    assign pending = irq & mask;
    assign valid   = |pending;

    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        index = '0;
        for (int unsigned i = NUM_IRQ; i > 0; i--) begin
            if (pending[i-1]) index = 4'(i - 1);
        end
    end

endmodule

// File: rtl/prv_trap_ctrl.sv
// Machine-mode trap sequencer: takes exceptions, masked interrupts and mret,
// drains the pipeline, strobes CSR updates and redirects fetch.
module prv_trap_ctrl
    import prv_trap_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NUM_IRQ     = 8,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               ex_valid,
    input  logic [3:0]         ex_cause,
    input  logic [XLEN-1:0]    ex_badaddr,
    input  logic [XLEN-1:0]    epc_in,
    input  logic               mret,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               pipe_ack,
    input  logic [XLEN-1:0]    mstatus,
    input  logic [XLEN-1:0]    mie,
    input  logic [XLEN-1:0]    mtvec,
    input  logic [XLEN-1:0]    mepc,
    output logic               pipe_flush,
    output logic               mip_rup,
    output logic [XLEN-1:0]    mip_next,
    output logic               mcause_rup,
    output logic [XLEN-1:0]    mcause_next,
    output logic               mepc_rup,
    output logic [XLEN-1:0]    mepc_next,
    output logic               mbadaddr_rup,
    output logic [XLEN-1:0]    mbadaddr_next,
    output logic               mstatus_rup,
    output logic [XLEN-1:0]    mstatus_next,
    output logic [XLEN-1:0]    insert_pc,
    output logic               insert_pc_valid
);

    trap_state_t     state;
    cause_t          lat_cause;
    logic [XLEN-3:0] lat_epc;
    logic [XLEN-1:0] lat_badaddr;
    logic            lat_exc;
    logic            lat_mret;

    logic            irq_valid;
    logic [3:0]      irq_index;
    logic            take_irq;
    logic [XLEN-1:0] mip_d;
    logic [XLEN-1:0] vec_base;
    logic [XLEN-1:0] vec_off;
    logic [XLEN-1:0] target;
    logic            unused_bits;

    assign unused_bits = ^{mie[XLEN-1:NUM_IRQ], epc_in[1:0]};

    prv_irq_prio #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .irq   (irq),
        .mask  (mie[NUM_IRQ-1:0]),
        .valid (irq_valid),
        .index (irq_index)
    );

    assign take_irq = mstatus[MSTATUS_MIE] & irq_valid;

    always_comb begin
        mip_d              = '0;
        mip_d[NUM_IRQ-1:0] = irq;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            lat_cause   <= '0;
            lat_epc     <= '0;
            lat_badaddr <= '0;
            lat_exc     <= 1'b0;
            lat_mret    <= 1'b0;
            mip_rup     <= 1'b0;
            mip_next    <= '0;
        end else begin
            mip_rup  <= 1'b1;
            mip_next <= mip_d;
            case (state)
                ST_IDLE: begin
                    if (ex_valid) begin
                        lat_cause.intr <= 1'b0;
                        lat_cause.code <= ex_cause;
                        lat_epc        <= epc_in[XLEN-1:2];
                        lat_badaddr    <= ex_badaddr;
                        lat_exc        <= 1'b1;
                        lat_mret       <= 1'b0;
                        state          <= ST_FLUSH;
                    end else if (take_irq) begin
                        lat_cause.intr <= 1'b1;
                        lat_cause.code <= irq_index;
                        lat_epc        <= epc_in[XLEN-1:2];
                        lat_exc        <= 1'b0;
                        lat_mret       <= 1'b0;
                        state          <= ST_FLUSH;
                    end else if (mret) begin
                        lat_exc  <= 1'b0;
                        lat_mret <= 1'b1;
                        state    <= ST_MRET;
                    end
                end
                ST_FLUSH:    if (pipe_ack) state <= ST_COMMIT;
                ST_COMMIT:   state <= ST_REDIRECT;
                ST_MRET:     state <= ST_REDIRECT;
                ST_REDIRECT: state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

    assign mcause_next   = {lat_cause.intr, {(XLEN-5){1'b0}}, lat_cause.code};
    assign mepc_next     = {lat_epc, 2'b00};
    assign mbadaddr_next = lat_badaddr;

    always_comb begin
        vec_base      = {mtvec[XLEN-1:2], 2'b00};
        vec_off       = '0;
        vec_off[5:2]  = lat_cause.code;
        if (lat_mret)
            target = mepc;
        else if (!lat_exc && VECTORED_EN && mtvec[1:0] == 2'b01)
            target = vec_base + vec_off;
        else
            target = vec_base;
    end

    always_comb begin
        pipe_flush      = 1'b0;
        mcause_rup      = 1'b0;
        mepc_rup        = 1'b0;
        mbadaddr_rup    = 1'b0;
        mstatus_rup     = 1'b0;
        mstatus_next    = '0;
        insert_pc_valid = 1'b0;
        insert_pc       = '0;
        case (state)
            ST_FLUSH: pipe_flush = 1'b1;
            ST_COMMIT: begin
                mcause_rup                                   = 1'b1;
                mepc_rup                                     = 1'b1;
                mbadaddr_rup                                 = lat_exc;
                mstatus_rup                                  = 1'b1;
                mstatus_next                                 = mstatus;
                mstatus_next[MSTATUS_MPIE]                   = mstatus[MSTATUS_MIE];
                mstatus_next[MSTATUS_MIE]                    = 1'b0;
                mstatus_next[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
            end
            ST_MRET: begin
                pipe_flush                 = 1'b1;
                mstatus_rup                = 1'b1;
                mstatus_next               = mstatus;
                mstatus_next[MSTATUS_MIE]  = mstatus[MSTATUS_MPIE];
                mstatus_next[MSTATUS_MPIE] = 1'b1;
            end
            ST_REDIRECT: begin
                insert_pc_valid = 1'b1;
                insert_pc       = target;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_prv_trap_ctrl.sv
// Directed and randomized checks of prv_trap_ctrl against a transaction-level
// trap model; the bench also plays the CSR file, feeding committed values back.
module tb_prv_trap_ctrl;

    localparam int XLEN    = 32;
    localparam int NUM_IRQ = 8;

    typedef enum {K_NONE, K_EXC, K_IRQ, K_MRET} kind_t;

    logic               CLK = 1'b0;
    logic               RST;
    logic               ex_valid;
    logic [3:0]         ex_cause;
    logic [XLEN-1:0]    ex_badaddr;
    logic [XLEN-1:0]    epc_in;
    logic               mret;
    logic [NUM_IRQ-1:0] irq;
    logic               pipe_ack;
    logic [XLEN-1:0]    mstatus;
    logic [XLEN-1:0]    mie;
    logic [XLEN-1:0]    mtvec;
    logic [XLEN-1:0]    mepc;
    logic               pipe_flush;
    logic               mip_rup;
    logic [XLEN-1:0]    mip_next;
    logic               mcause_rup;
    logic [XLEN-1:0]    mcause_next;
    logic               mepc_rup;
    logic [XLEN-1:0]    mepc_next;
    logic               mbadaddr_rup;
    logic [XLEN-1:0]    mbadaddr_next;
    logic               mstatus_rup;
    logic [XLEN-1:0]    mstatus_next;
    logic [XLEN-1:0]    insert_pc;
    logic               insert_pc_valid;

    prv_trap_ctrl #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ), .VECTORED_EN(1'b1)) dut (
        .CLK(CLK), .RST(RST),
        .ex_valid(ex_valid), .ex_cause(ex_cause), .ex_badaddr(ex_badaddr),
        .epc_in(epc_in), .mret(mret), .irq(irq), .pipe_ack(pipe_ack),
        .mstatus(mstatus), .mie(mie), .mtvec(mtvec), .mepc(mepc),
        .pipe_flush(pipe_flush), .mip_rup(mip_rup), .mip_next(mip_next),
        .mcause_rup(mcause_rup), .mcause_next(mcause_next),
        .mepc_rup(mepc_rup), .mepc_next(mepc_next),
        .mbadaddr_rup(mbadaddr_rup), .mbadaddr_next(mbadaddr_next),
        .mstatus_rup(mstatus_rup), .mstatus_next(mstatus_next),
        .insert_pc(insert_pc), .insert_pc_valid(insert_pc_valid)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    logic [XLEN-1:0] obs_mcause, obs_mstat, obs_ipc;
    logic            obs_bad_rup;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic kind_t req_kind();
        logic [NUM_IRQ-1:0] p;
        p = irq & mie[NUM_IRQ-1:0];
        if (ex_valid) return K_EXC;
        if (mstatus[3] && p != 0) return K_IRQ;
        if (mret) return K_MRET;
        return K_NONE;
    endfunction

    // Presents the current inputs as a request and follows the sequence to IDLE.
    task automatic run_step(input string tag, input int ack_delay);
        kind_t              k;
        logic [NUM_IRQ-1:0] p, low;
        logic [XLEN-1:0]    e_cause, e_target, e_mstat, e_epc, e_bad, base;
        int                 code;
        k     = req_kind();
        p     = irq & mie[NUM_IRQ-1:0];
        low   = p & (~p + 1'b1);
        code  = $clog2(low);
        base  = mtvec & ~32'h3;
        e_epc = epc_in & ~32'h3;
        e_bad = ex_badaddr;
        e_mstat = mstatus;
        if (k == K_EXC) begin
            e_cause  = {28'h0, ex_cause};
            e_target = base;
        end else begin
            e_cause  = 32'h8000_0000 + code;
            e_target = (mtvec[1:0] == 2'b01) ? base + 4 * code : base;
        end
        if (k == K_MRET) begin
            e_target   = mepc;
            e_mstat[3] = mstatus[7];
            e_mstat[7] = 1'b1;
        end else begin
            e_mstat[7]     = mstatus[3];
            e_mstat[3]     = 1'b0;
            e_mstat[12:11] = 2'b11;
        end

        tick();
        case (k)
            K_NONE: begin
                chk({tag, ".idle_flush"}, {31'h0, pipe_flush}, 32'h0);
                chk({tag, ".idle_cause_rup"}, {31'h0, mcause_rup}, 32'h0);
                chk({tag, ".mip_next"}, mip_next, {24'h0, irq});
            end
            K_MRET: begin
                mret = 1'b0;
                chk({tag, ".mret_flush"}, {31'h0, pipe_flush}, 32'h1);
                chk({tag, ".mret_mst_rup"}, {31'h0, mstatus_rup}, 32'h1);
                chk({tag, ".mret_mstatus"}, mstatus_next, e_mstat);
                obs_mstat = mstatus_next;
                mstatus = e_mstat;
                tick();
                chk({tag, ".mret_valid"}, {31'h0, insert_pc_valid}, 32'h1);
                chk({tag, ".mret_pc"}, insert_pc, e_target);
                obs_ipc = insert_pc;
                tick();
                chk({tag, ".mret_done"}, {31'h0, insert_pc_valid}, 32'h0);
            end
            default: begin
                ex_valid = 1'b0;
                mret     = 1'b0;
                chk({tag, ".flush"}, {31'h0, pipe_flush}, 32'h1);
                repeat (ack_delay) begin
                    irq      = NUM_IRQ'($urandom);
                    ex_valid = 1'($urandom_range(0, 1));
                    ex_cause = 4'($urandom);
                    tick();
                    chk({tag, ".flush_hold"}, {31'h0, pipe_flush}, 32'h1);
                end
                pipe_ack = 1'b1;
                tick();
                pipe_ack = 1'b0;
                ex_valid = 1'b0;
                chk({tag, ".mcause_rup"}, {31'h0, mcause_rup}, 32'h1);
                chk({tag, ".mcause"}, mcause_next, e_cause);
                chk({tag, ".mepc_rup"}, {31'h0, mepc_rup}, 32'h1);
                chk({tag, ".mepc"}, mepc_next, e_epc);
                chk({tag, ".mbad_rup"}, {31'h0, mbadaddr_rup}, {31'h0, k == K_EXC});
                if (k == K_EXC) chk({tag, ".mbad"}, mbadaddr_next, e_bad);
                chk({tag, ".mst_rup"}, {31'h0, mstatus_rup}, 32'h1);
                chk({tag, ".mstatus"}, mstatus_next, e_mstat);
                obs_mcause  = mcause_next;
                obs_mstat   = mstatus_next;
                obs_bad_rup = mbadaddr_rup;
                mstatus = e_mstat;
                mepc    = e_epc;
                tick();
                chk({tag, ".redir_valid"}, {31'h0, insert_pc_valid}, 32'h1);
                chk({tag, ".redir_flush"}, {31'h0, pipe_flush}, 32'h0);
                chk({tag, ".insert_pc"}, insert_pc, e_target);
                obs_ipc = insert_pc;
                tick();
                chk({tag, ".redir_done"}, {31'h0, insert_pc_valid}, 32'h0);
            end
        endcase
    endtask

    initial begin
        RST = 1'b1; ex_valid = 1'b0; ex_cause = '0; ex_badaddr = '0; epc_in = '0;
        mret = 1'b0; irq = '0; pipe_ack = 1'b0; mstatus = '0; mie = '0;
        mtvec = '0; mepc = '0;
        tick();
        tick();
        chk("rst_mip_rup", {31'h0, mip_rup}, 32'h0);
        chk("rst_flush", {31'h0, pipe_flush}, 32'h0);
        chk("rst_ipc_valid", {31'h0, insert_pc_valid}, 32'h0);
        chk("rst_mcause", mcause_next, 32'h0);
        chk("rst_mepc", mepc_next, 32'h0);
        chk("rst_mstatus", mstatus_next, 32'h0);
        chk("rst_ipc", insert_pc, 32'h0);
        chk("rst_mip", mip_next, 32'h0);
        RST = 1'b0;
        tick();
        chk("mip_rup_on", {31'h0, mip_rup}, 32'h1);

        // Synchronous exception, pipeline ack after two cycles.
        ex_valid = 1'b1; ex_cause = 4'd2; epc_in = 32'h200; ex_badaddr = 32'hBAD0_0001;
        mtvec = 32'h100;
        run_step("exc", 2);
        chk("exc_mcause_k", obs_mcause, 32'h2);
        chk("exc_ipc_k", obs_ipc, 32'h100);

        // Vectored timer interrupt.
        irq = 8'h80; mie = 32'h80; mstatus = 32'h8; mtvec = 32'h101; epc_in = 32'h344;
        run_step("irq7", 0);
        chk("irq7_mcause_k", obs_mcause, 32'h8000_0007);
        chk("irq7_ipc_k", obs_ipc, 32'h11C);
        chk("irq7_mstatus_k", obs_mstat, 32'h1880);

        // Exception beats a simultaneous interrupt, which is taken afterwards.
        irq = 8'h08; mie = 32'h08; mstatus = 32'h8; mtvec = 32'h101;
        ex_valid = 1'b1; ex_cause = 4'd5; ex_badaddr = 32'hDEAD; epc_in = 32'h500;
        run_step("exirq", 1);
        chk("exirq_mcause_k", obs_mcause, 32'h5);
        chk("exirq_bad_rup_k", {31'h0, obs_bad_rup}, 32'h1);
        chk("exirq_ipc_k", obs_ipc, 32'h100);
        irq = 8'h08; mstatus[3] = 1'b1;
        run_step("retake", 0);
        chk("retake_mcause_k", obs_mcause, 32'h8000_0003);
        chk("retake_ipc_k", obs_ipc, 32'h10C);

        // mret restores MIE from MPIE.
        irq = '0; mepc = 32'h404; mstatus = 32'h80; mret = 1'b1;
        run_step("mret", 0);
        chk("mret_mstatus_k", obs_mstat, 32'h88);
        chk("mret_ipc_k", obs_ipc, 32'h404);

        // Pending interrupt with global enable clear.
        irq = 8'h08; mie = 32'h08; mstatus = 32'h0;
        run_step("masked", 0);
        chk("masked_mip3", {31'h0, mip_next[3]}, 32'h1);

        // Reset during FLUSH abandons the trap.
        irq = '0; ex_valid = 1'b1; ex_cause = 4'd7;
        tick();
        ex_valid = 1'b0;
        chk("rstf_flush", {31'h0, pipe_flush}, 32'h1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        pipe_ack = 1'b1;
        chk("rstf_idle", {31'h0, pipe_flush}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rstf_no_rup", {28'h0, mcause_rup, mepc_rup, mstatus_rup, insert_pc_valid}, 32'h0);
        end
        pipe_ack = 1'b0;

        for (int n = 0; n < 60; n++) begin
            mtvec      = $urandom;
            mie        = $urandom;
            irq        = NUM_IRQ'($urandom);
            mstatus    = $urandom;
            mepc       = $urandom;
            epc_in     = $urandom;
            ex_badaddr = $urandom;
            ex_cause   = 4'($urandom);
            ex_valid   = ($urandom_range(0, 3) == 0);
            mret       = 1'($urandom_range(0, 1));
            run_step("rnd", $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule
